// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants for the S/PDIF frame scheduler.
//   Preamble codes driven on ENC_PRE, the channel-status block length,
//   and the time-slot map of the 28-bit subframe word (slots 4..31).
//   Bit n of the packed word carries time slot SLOT_BASE+n.
package spdif_pkg;

  localparam logic [1:0] PRE_B = 2'd0;  // block start, subframe A of frame 0
  localparam logic [1:0] PRE_M = 2'd1;  // subframe A, other frames
  localparam logic [1:0] PRE_W = 2'd2;  // every subframe B

  localparam int FRAMES_PER_BLOCK = 192;
  localparam int AUDIO_W          = 24;

  localparam int SLOT_BASE = 4;
  localparam int SLOT_V    = 28;
  localparam int SLOT_U    = 29;
  localparam int SLOT_C    = 30;
  localparam int SLOT_P    = 31;
  localparam int WORD_W    = SLOT_P - SLOT_BASE + 1;

  // Channel-status bit for a frame: only bits 0..31 can be non-zero.
  function automatic logic cs_bit(input logic [31:0] cs_low, input logic [7:0] idx);
    return (idx < 8'd32) ? cs_low[idx[4:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/spdif_frame_sched_if.sv
// spdif_frame_sched_if: source + encoder side signals of the scheduler.
//   ENABLE              fetch permit
//   S_VALID/S_READY     PCM pair handshake, S_LEFT/S_RIGHT payload
//   ENC_REQ             encoder wants the next subframe
//   ENC_LOAD            ENC_WORD/ENC_PRE/FRAME_IDX were just updated
//   UNDERRUN            subframe A loaded without a buffered pair
// master = source/encoder side, slave = scheduler.
interface spdif_frame_sched_if
  import spdif_pkg::*;
#(
  parameter int SAMPLE_W = 24
);
  logic                ENABLE;
  logic                S_VALID;
  logic                S_READY;
  logic [SAMPLE_W-1:0] S_LEFT;
  logic [SAMPLE_W-1:0] S_RIGHT;
  logic                ENC_REQ;
  logic                ENC_LOAD;
  logic [WORD_W-1:0]   ENC_WORD;
  logic [1:0]          ENC_PRE;
  logic [7:0]          FRAME_IDX;
  logic                UNDERRUN;

  modport master (
    output ENABLE, S_VALID, S_LEFT, S_RIGHT, ENC_REQ,
    input  S_READY, ENC_LOAD, ENC_WORD, ENC_PRE, FRAME_IDX, UNDERRUN
  );

  modport slave (
    input  ENABLE, S_VALID, S_LEFT, S_RIGHT, ENC_REQ,
    output S_READY, ENC_LOAD, ENC_WORD, ENC_PRE, FRAME_IDX, UNDERRUN
  );
endinterface

// File: rtl/spdif_subframe_pack.sv
// spdif_subframe_pack: combinational subframe word builder.
//   sample  PCM sample, SAMPLE_W bits, left-justified into the 24-bit field
//   v, c    validity and channel-status bits (user bit is always 0)
//   word    28-bit word, bit0 = slot 4, parity in slot 31 makes the
//           count of ones over slots 4..31 even
module spdif_subframe_pack
  import spdif_pkg::*;
#(
  parameter int SAMPLE_W = 24
) (
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                v,
  input  logic                c,
  output logic [WORD_W-1:0]   word
);
  logic [AUDIO_W-1:0] audio;
  logic [WORD_W-2:0]  body;

  // Narrow samples sit in the MSBs of the audio field, LSBs zero.
  assign audio = AUDIO_W'(sample) << (AUDIO_W - SAMPLE_W);

  always_comb begin
    body                      = '0;
    body[AUDIO_W-1:0]         = audio;
    body[SLOT_V - SLOT_BASE]  = v;
    body[SLOT_U - SLOT_BASE]  = 1'b0;
    body[SLOT_C - SLOT_BASE]  = c;
  end

  assign word = {^body, body};

endmodule

// File: rtl/spdif_frame_sched.sv
// spdif_frame_sched: S/PDIF transmit sequencer.
//   Fetches stereo pairs from the source (one-pair buffer), and on each
//   encoder request loads the next subframe: A carries the left sample,
//   B the right sample of the same pair. Tracks the 192-frame block
//   position for preamble and channel-status selection.
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   bus          spdif_frame_sched_if.slave (source + encoder signals)
// Parameters:
//   SAMPLE_W     PCM width 16..24, must match the interface instance
//   CS_LOW       channel-status bits 0..31 (bits 32..191 are zero)
// Build option:
//   SPDIF_UNDERRUN_HOLD_EN  defined: an underrun resends the previous pair
//                           with V=0; undefined: zero audio with V=1.
module spdif_frame_sched
  import spdif_pkg::*;
#(
  parameter int          SAMPLE_W = 24,
  parameter logic [31:0] CS_LOW   = 32'h0200_0004
) (
  input  logic CLK,
  input  logic RST_N,
  spdif_frame_sched_if.slave bus
);

  localparam logic [0:0] SEND_A = 1'b0;
  localparam logic [0:0] SEND_B = 1'b1;

  logic [0:0]          state;
  logic [7:0]          frame_cnt;   // frame of the next subframe to load

  logic                buf_full;
  logic [SAMPLE_W-1:0] buf_l, buf_r;
  logic [SAMPLE_W-1:0] cur_l, cur_r;
  logic                cur_v;       // V of the last A, reused by its B

  logic                hs;
  logic                take_a;
  logic                und_now;
  logic [SAMPLE_W-1:0] sel_sample;
  logic                sel_v;
  logic                sel_c;
  logic [1:0]          sel_pre;
  logic [WORD_W-1:0]   packed_word;

  assign bus.S_READY = bus.ENABLE && !buf_full;
  assign hs          = bus.S_VALID && bus.S_READY;
  assign take_a      = bus.ENC_REQ && (state == SEND_A);
  assign und_now     = take_a && !buf_full;
  assign sel_c       = cs_bit(CS_LOW, frame_cnt);

  // Subframe content for a load happening this cycle.
  always_comb begin
    sel_sample = '0;
    sel_v      = 1'b0;
    sel_pre    = PRE_W;
    if (state == SEND_A) begin
      sel_pre = (frame_cnt == 8'd0) ? PRE_B : PRE_M;
      if (buf_full) begin
        sel_sample = buf_l;
        sel_v      = 1'b0;
      end else begin
`ifdef SPDIF_UNDERRUN_HOLD_EN
        sel_sample = cur_l;
        sel_v      = 1'b0;
`else
        sel_sample = '0;
        sel_v      = 1'b1;
`endif
      end
    end else begin
      // B always follows its A: the current pair was settled at A time.
      sel_sample = cur_r;
      sel_v      = cur_v;
    end
  end

  spdif_subframe_pack #(
    .SAMPLE_W (SAMPLE_W)
  ) u_pack (
    .sample (sel_sample),
    .v      (sel_v),
    .c      (sel_c),
    .word   (packed_word)
  );

  // Next-pair buffer. A consuming A-load and a handshake never coincide,
  // because S_READY is low whenever the buffer is full.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
    end else begin
      if (take_a && buf_full) begin
        buf_full <= 1'b0;
      end else if (hs) begin
        buf_full <= 1'b1;
      end
      if (hs) begin
        buf_l <= bus.S_LEFT;
        buf_r <= bus.S_RIGHT;
      end
    end
  end

  // Subframe sequencing: A/B toggle, current pair, block position.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= SEND_A;
      frame_cnt <= '0;
      cur_l     <= '0;
      cur_r     <= '0;
      cur_v     <= 1'b0;
    end else if (bus.ENC_REQ) begin
      if (state == SEND_A) begin
        state <= SEND_B;
        cur_v <= sel_v;
        if (buf_full) begin
          cur_l <= buf_l;
          cur_r <= buf_r;
        end else begin
`ifndef SPDIF_UNDERRUN_HOLD_EN
          // Zero the pair so the following B also carries silence.
          cur_l <= '0;
          cur_r <= '0;
`endif
        end
      end else begin
        state     <= SEND_A;
        frame_cnt <= (frame_cnt == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_cnt + 8'd1;
      end
    end
  end

  // Encoder-facing registers: one cycle after ENC_REQ, held until next load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.ENC_LOAD  <= 1'b0;
      bus.UNDERRUN  <= 1'b0;
      bus.ENC_WORD  <= '0;
      bus.ENC_PRE   <= PRE_B;
      bus.FRAME_IDX <= '0;
    end else begin
      bus.ENC_LOAD <= bus.ENC_REQ;
      bus.UNDERRUN <= und_now;
      if (bus.ENC_REQ) begin
        bus.ENC_WORD  <= packed_word;
        bus.ENC_PRE   <= sel_pre;
        bus.FRAME_IDX <= frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_spdif_frame_sched.sv
// Bench for spdif_frame_sched: a subframe-position model (absolute
// subframe number within the 384-subframe block) checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_spdif_frame_sched;
  import spdif_pkg::*;

  localparam logic [31:0] CS = 32'h0200_0004;
`ifdef SPDIF_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   src_on = 1'b0;

  spdif_frame_sched_if #(.SAMPLE_W(24)) bus0 ();
  spdif_frame_sched_if #(.SAMPLE_W(16)) bus1 ();

  spdif_frame_sched #(.SAMPLE_W(24), .CS_LOW(CS)) dut0 (.CLK(CLK), .RST_N(RST_N), .bus(bus0));
  spdif_frame_sched #(.SAMPLE_W(16), .CS_LOW(CS)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));

  assign bus1.ENC_REQ = bus0.ENC_REQ;

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] cs_v = CS;
  bit          m_full;
  logic [23:0] m_bl, m_br, m_cl, m_cr;
  bit          m_cv;
  int          m_pos;           // subframe number within block, 0..383
  bit          e_load, e_und;
  logic [27:0] e_word;
  logic [1:0]  e_pre;
  logic [7:0]  e_idx;

  function automatic logic [27:0] mk(input logic [23:0] a, input bit v, input bit c);
    logic [27:0] w;
    w = 28'(a) | (28'(v) << 24) | (28'(c) << 26);
    if ($countones(w) % 2 == 1) w = w | 28'h800_0000;
    return w;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_full = 0; m_bl = 0; m_br = 0; m_cl = 0; m_cr = 0; m_cv = 0; m_pos = 0;
      e_load = 0; e_und = 0; e_word = 0; e_pre = 0; e_idx = 0;
    end else begin
      bit hs;
      hs = bus0.S_VALID && bus0.ENABLE && !m_full;
      e_load = bus0.ENC_REQ;
      e_und = 0;
      if (bus0.ENC_REQ) begin
        logic [7:0] fr;
        bit c;
        fr = 8'(m_pos / 2);
        c = (fr < 32) ? cs_v[fr[4:0]] : 1'b0;
        e_idx = fr;
        if (m_pos % 2 == 0) begin
          e_pre = (fr == 0) ? 2'd0 : 2'd1;
          if (m_full) begin
            m_cl = m_bl; m_cr = m_br; m_cv = 0; m_full = 0;
          end else begin
            e_und = 1;
            if (!HOLD) begin m_cl = 0; m_cr = 0; m_cv = 1; end
            else m_cv = 0;
          end
          e_word = mk(m_cl, m_cv, c);
        end else begin
          e_pre = 2'd2;
          e_word = mk(m_cr, m_cv, c);
        end
        m_pos = (m_pos + 1) % 384;
      end
      if (hs) begin m_full = 1; m_bl = bus0.S_LEFT; m_br = bus0.S_RIGHT; end
    end
  end

  always @(negedge CLK) begin
    chk("ENC_LOAD", 32'(bus0.ENC_LOAD), 32'(e_load));
    chk("ENC_WORD", 32'(bus0.ENC_WORD), 32'(e_word));
    chk("ENC_PRE", 32'(bus0.ENC_PRE), 32'(e_pre));
    chk("FRAME_IDX", 32'(bus0.FRAME_IDX), 32'(e_idx));
    chk("UNDERRUN", 32'(bus0.UNDERRUN), 32'(e_und));
    chk("S_READY", 32'(bus0.S_READY), 32'(bus0.ENABLE && !m_full));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
    cyc++;
    if (src_on) begin
      bus0.S_VALID = 1'b1;
      bus0.S_LEFT  = 24'(cyc * 32'h01_0203) ^ 24'hA5A5A5;
      bus0.S_RIGHT = 24'(cyc * 32'h03_0507) ^ 24'h3C3C3C;
    end
  endtask

  task automatic req_pulse();
    bus0.ENC_REQ = 1'b1;
    tick();
    bus0.ENC_REQ = 1'b0;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    bus0.S_VALID = 1'b1;
    bus0.S_LEFT = l;
    bus0.S_RIGHT = r;
    for (int i = 0; i < 20 && !bus0.S_READY; i++) tick();
    chk("push_ready", 32'(bus0.S_READY), 32'd1);
    tick();
    bus0.S_VALID = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nc, nw, nu, prev_idx;
    bus0.ENABLE = 1; bus0.S_VALID = 0; bus0.S_LEFT = 0; bus0.S_RIGHT = 0; bus0.ENC_REQ = 0;
    bus1.ENABLE = 1; bus1.S_VALID = 1; bus1.S_LEFT = 16'hABCD; bus1.S_RIGHT = 16'h1234;
    RST_N = 0;
    repeat (3) tick();
    chk("rst_word", 32'(bus0.ENC_WORD), 0);
    chk("rst_load", 32'(bus0.ENC_LOAD), 0);
    chk("rst_idx", 32'(bus0.FRAME_IDX), 0);
    chk("rst_und", 32'(bus0.UNDERRUN), 0);
    RST_N = 1;
    tick(); tick();

    // No source: frame 0 underruns.
    req_pulse();
    chk("u0a_pre", 32'(bus0.ENC_PRE), 0);
    chk("u0a_und", 32'(bus0.UNDERRUN), 1);
    chk("u0a_word", 32'(bus0.ENC_WORD), HOLD ? 32'h0 : 32'h900_0000);
    chk("w16_a", 32'(bus1.ENC_WORD), 32'h0AB_CD00);
    req_pulse();
    chk("u0b_pre", 32'(bus0.ENC_PRE), 2);
    chk("u0b_und", 32'(bus0.UNDERRUN), 0);
    chk("w16_b", 32'(bus1.ENC_WORD), 32'h812_3400);

    // Frame 1: extreme samples.
    push(24'h800001, 24'h7FFFFF);
    chk("full_nready", 32'(bus0.S_READY), 0);
    req_pulse();
    chk("f1a_word", 32'(bus0.ENC_WORD), 32'h080_0001);
    chk("f1a_idx", 32'(bus0.FRAME_IDX), 1);
    chk("f1a_pre", 32'(bus0.ENC_PRE), 1);
    chk("f1a_ready", 32'(bus0.S_READY), 1);
    req_pulse();
    chk("f1b_word", 32'(bus0.ENC_WORD), 32'h87F_FFFF);

    // Frame 2: underrun, C=1.
    req_pulse();
    chk("f2a_und", 32'(bus0.UNDERRUN), 1);
    chk("f2a_word", 32'(bus0.ENC_WORD), HOLD ? 32'hC80_0001 : 32'h500_0000);
    req_pulse();
    chk("f2b_word", 32'(bus0.ENC_WORD), HOLD ? 32'h47F_FFFF : 32'h500_0000);

    // Continuous source over two block boundaries, mixed request spacing.
    src_on = 1;
    tick(); tick();
    nb = 0; nc = 0; nw = 0; nu = 0; prev_idx = 2;
    for (int i = 0; i < 770; i++) begin
      req_pulse();
      if (bus0.ENC_PRE == 2'd0) nb++;
      if (bus0.ENC_WORD[26]) nc++;
      if (prev_idx == 191 && bus0.FRAME_IDX == 8'd0) nw++;
      nu += int'(bus0.UNDERRUN);
      prev_idx = int'(bus0.FRAME_IDX);
      repeat (i % 3) tick();
    end
    src_on = 0;
    bus0.S_VALID = 0;
    chk("blk_preB", 32'(nb), 2);
    chk("blk_cbits", 32'(nc), 8);
    chk("blk_wraps", 32'(nw), 2);
    chk("blk_und", 32'(nu), 0);

    // ENABLE low: buffered pair still used, then underrun.
    bus0.ENABLE = 0;
    bus0.S_VALID = 1;
    tick();
    chk("dis_nready", 32'(bus0.S_READY), 0);
    req_pulse();
    chk("dis_a1_und", 32'(bus0.UNDERRUN), 0);
    req_pulse();
    req_pulse();
    chk("dis_a2_und", 32'(bus0.UNDERRUN), 1);
    req_pulse();

    // Run to frame 57, load A, refill the buffer, then reset mid-frame.
    bus0.ENABLE = 1;
    src_on = 1;
    tick();
    for (int i = 0; i < 400 && m_pos != 114; i++) req_pulse();
    req_pulse();
    tick();
    src_on = 0;
    bus0.S_VALID = 0;
    chk("pre_rst_idx", 32'(bus0.FRAME_IDX), 57);
    #1;
    RST_N = 0;
    #1;
    chk("mrst_word", 32'(bus0.ENC_WORD), 0);
    chk("mrst_idx", 32'(bus0.FRAME_IDX), 0);
    chk("mrst_pre", 32'(bus0.ENC_PRE), 0);
    tick();
    RST_N = 1;
    tick();
    req_pulse();
    chk("post_pre", 32'(bus0.ENC_PRE), 0);
    chk("post_idx", 32'(bus0.FRAME_IDX), 0);
    chk("post_und", 32'(bus0.UNDERRUN), 1);
    req_pulse();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
